perif_uart_tx: RTL and testbench

Memory-mapped UART transmitter occupying the peripheral chip-select slot (mem_cs = 2'b11) of the CPU memory bus. It is the responder for CPU loads and stores on the shared 64-bit tri-state data bus, in parallel with RAM and ROM. CPU stores to the DATA register are queued in a FIFO and serialized as 8N1 frames on `tx`. Status and configuration are readable and writable through the same bus.

---
 rtl/perif_pkg.sv | 13 +
 rtl/perif_fifo.sv | 41 ++++
 rtl/perif_uart_tx.sv | 137 +++++++++++++
 tb/tb_perif_uart_tx.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/perif_pkg.sv
// perif_pkg: register map, status bit positions and transmitter states for perif_uart_tx
package perif_pkg;
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_BAUD   = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_CNT   = 8;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/perif_fifo.sv
// perif_fifo: synchronous byte FIFO; a push into a full FIFO is accepted only alongside a pop
module perif_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full,
  output logic [4:0] count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic do_push, do_pop;
  assign empty = wr_q == rd_q;
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count = 5'(wr_q - rd_q);
  assign dout  = mem_q[rd_q[AW-1:0]];
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d    = wr_q + {{AW{1'b0}}, do_push};
    rd_d    = rd_q + {{AW{1'b0}}, do_pop};
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/perif_uart_tx.sv
// perif_uart_tx: memory-mapped 8N1 UART transmitter on the shared 64-bit tri-state data bus
module perif_uart_tx
  import perif_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  inout  wire  [63:0] data,
  input  logic        cs,
  input  logic        write_en,
  input  logic        read_en,
  input  logic [1:0]  size,
  output logic        tx,
  output logic        irq
);
  logic [1:0] idx;
  logic wr, push_req, pop_req, drop, status_rd, last;
  logic [7:0] fifo_dout;
  logic fifo_empty, fifo_full;
  logic [4:0] fifo_count;
  logic [63:0] status, rdata;
  tx_state_t state_q, state_d;
  logic [15:0] baud_q, baud_d, div_q, div_d, cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_q, bit_d;
  logic tx_en_q, tx_en_d, irq_en_q, irq_en_d, ovf_q, ovf_d, tx_q, tx_d, irq_q, irq_d;
  logic unused_bits;
  assign unused_bits = ^{size, address[31:5], address[2:0], data[63:16]};
  perif_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(push_req),
    .pop(pop_req),
    .din(data[7:0]),
    .dout(fifo_dout),
    .empty(fifo_empty),
    .full(fifo_full),
    .count(fifo_count)
  );
  always_comb begin
    idx       = address[4:3];
    wr        = cs && write_en;
    push_req  = wr && idx == REG_DATA;
    status_rd = cs && read_en && idx == REG_STATUS;
    pop_req   = state_q == IDLE && tx_en_q && !fifo_empty;
    drop      = push_req && fifo_full && !pop_req;
    baud_d    = (wr && idx == REG_BAUD) ? data[15:0] : baud_q;
    {irq_en_d, tx_en_d} = (wr && idx == REG_CTRL) ? data[1:0] : {irq_en_q, tx_en_q};
    ovf_d     = drop || (ovf_q && !status_rd);
    irq_d     = irq_en_q && fifo_empty && state_q == IDLE;
    status    = '0;
    status[ST_EMPTY]    = fifo_empty;
    status[ST_FULL]     = fifo_full;
    status[ST_BUSY]     = state_q != IDLE;
    status[ST_OVF]      = ovf_q;
    status[ST_CNT +: 5] = fifo_count;
    rdata = idx == REG_STATUS ? status :
            idx == REG_BAUD   ? {48'd0, baud_q} :
            idx == REG_CTRL   ? {62'd0, irq_en_q, tx_en_q} : '0;
  end
  assign data = (cs && read_en && !write_en) ? rdata : 'z;
  // Each bit slot lasts div_q cycles: cnt_q counts down to 0, then the next slot begins.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q - 16'd1;
    shift_d = shift_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    last    = cnt_q == '0;
    case (state_q)
      IDLE: begin
        cnt_d = cnt_q;
        tx_d  = 1'b1;
        if (pop_req) begin
          state_d = START;
          div_d   = baud_q == '0 ? 16'd1 : baud_q;
          cnt_d   = div_d - 16'd1;
          shift_d = fifo_dout;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (last) begin
          state_d = DATA;
          cnt_d   = div_q - 16'd1;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (last) begin
          cnt_d   = div_q - 16'd1;
          state_d = bit_q == 3'd7 ? STOP : DATA;
          bit_d   = bit_q + 3'd1;
          shift_d = shift_q >> 1;
          tx_d    = bit_q == 3'd7 ? 1'b1 : shift_q[1];
        end
      end
      STOP: begin
        if (last) state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      baud_q   <= DEFAULT_DIV;
      div_q    <= 16'd1;
      cnt_q    <= '0;
      shift_q  <= '0;
      bit_q    <= '0;
      tx_en_q  <= 1'b0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      tx_q     <= 1'b1;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      tx_en_q  <= tx_en_d;
      irq_en_q <= irq_en_d;
      ovf_q    <= ovf_d;
      tx_q     <= tx_d;
      irq_q    <= irq_d;
    end
  end
  assign tx  = tx_q;
  assign irq = irq_q;
endmodule

// File: tb/tb_perif_uart_tx.sv
// tb_perif_uart_tx: randomized bus traffic against a frame-level model of the 8N1 transmitter
module tb_perif_uart_tx;
  import perif_pkg::*;
  localparam int DEPTH = 8;
  logic clock = 0, reset = 1, cs = 0, write_en = 0, read_en = 0, tb_drv = 0;
  logic [31:0] address = 0;
  logic [1:0] size = 0;
  logic [63:0] tb_val = 0;
  wire [63:0] data_bus;
  logic tx, irq;
  int checks = 0, fails = 0, cyc = 0;
  logic tx_log [8192];
  logic irq_log [8192];
  logic [7:0] exp_q[$];
  assign data_bus = tb_drv ? tb_val : 'z;
  pullup (data_bus);
  perif_uart_tx #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd868)) dut (
    .clock(clock), .reset(reset), .address(address), .data(data_bus), .cs(cs),
    .write_en(write_en), .read_en(read_en), .size(size), .tx(tx), .irq(irq)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (cyc < 8192) begin
    tx_log[cyc] = tx;
    irq_log[cyc] = irq;
  end
  function automatic logic [31:0] addr_of(input logic [1:0] idx);
    return ($urandom & 32'hFFFF_FFE7) | {27'd0, idx, 3'd0};
  endfunction
  // {slot inconsistent, tx before start, idle, stop, data[7:0], start} seen on tx for a frame at s
  function automatic logic [12:0] frame_obs(input int s, input int d);
    logic [12:0] o;
    o = '0;
    o[11] = tx_log[s - 1];
    for (int i = 0; i < 10; i++) begin
      o[i] = tx_log[s + i * d];
      for (int k = 1; k < d; k++) if (tx_log[s + i * d + k] != o[i]) o[12] = 1'b1;
    end
    o[10] = tx_log[s + 10 * d];
    return o;
  endfunction
  task automatic bus_write(input logic [1:0] idx, input logic [63:0] val);
    @(negedge clock);
    cs = 1; write_en = 1; read_en = 0; address = addr_of(idx); size = 2'($urandom);
    tb_val = val; tb_drv = 1;
    @(posedge clock); #1;
    cs = 0; write_en = 0; tb_drv = 0;
  endtask
  task automatic bus_read(input logic [1:0] idx, output logic [63:0] val);
    @(negedge clock);
    cs = 1; read_en = 1; address = addr_of(idx); size = 2'($urandom);
    #2 val = data_bus;
    @(posedge clock); #1;
    cs = 0; read_en = 0;
  endtask
  task automatic test_reset();
    logic [63:0] v;
    reset = 1;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b want 0", irq); end
    @(negedge clock);
    reset = 0; read_en = 1; address = addr_of(REG_BAUD);
    #2;
    checks++; if (data_bus !== '1) begin fails++; $display("FAIL undriven_bus: got %h want all ones", data_bus); end
    write_en = 1; tb_drv = 1; tb_val = 64'h1234;
    @(posedge clock); #1;
    write_en = 0; read_en = 0; tb_drv = 0;
    bus_read(REG_STATUS, v);
    checks++; if (v !== 64'h1) begin fails++; $display("FAIL reset_status: got %h want 1", v); end
    bus_read(REG_BAUD, v);
    checks++; if (v !== 64'd868) begin fails++; $display("FAIL reset_baud: got %0d want 868", v); end
    bus_read(REG_CTRL, v);
    checks++; if (v !== 64'd0) begin fails++; $display("FAIL reset_ctrl: got %h want 0", v); end
    bus_read(REG_DATA, v);
    checks++; if (v !== 64'd0) begin fails++; $display("FAIL data_read: got %h want 0", v); end
  endtask
  task automatic test_single_frame();
    int w, nb, first;
    logic [12:0] obs;
    bus_write(REG_BAUD, {32'($urandom), 16'($urandom), 16'd4});
    bus_write(REG_CTRL, {32'($urandom), 30'($urandom), 2'b01});
    bus_write(REG_DATA, {32'($urandom), 24'($urandom), 8'hA5});
    w = cyc;
    @(negedge clock);
    cs = 1; read_en = 1; address = addr_of(REG_STATUS);
    nb = 0; first = -1;
    repeat (45) begin
      #2;
      if (data_bus[ST_BUSY]) begin
        nb++;
        if (first < 0) first = cyc;
      end
      @(negedge clock);
    end
    cs = 0; read_en = 0;
    checks++; if (nb != 40) begin fails++; $display("FAIL busy_len: got %0d want 40", nb); end
    checks++; if (first != w + 1) begin fails++; $display("FAIL busy_start: got %0d want %0d", first, w + 1); end
    obs = frame_obs(w + 1, 4);
    checks++; if (obs !== {4'b0111, 8'hA5, 1'b0}) begin fails++; $display("FAIL frame_a5: got %b want %b", obs, {4'b0111, 8'hA5, 1'b0}); end
  endtask
  task automatic test_random_frames();
    int d, n, s;
    logic [15:0] dw;
    logic [7:0] b;
    logic [12:0] obs;
    for (int r = 0; r < 2; r++) begin
      dw = r == 0 ? 16'($urandom_range(2, 5)) : 16'd0;
      d = dw == 0 ? 1 : int'(dw);
      bus_write(REG_BAUD, {48'($urandom), dw});
      n = $urandom_range(2, 4);
      s = 0;
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        bus_write(REG_DATA, {32'($urandom), 24'($urandom), b});
        if (k == 0) s = cyc + 1;
      end
      repeat (n * (10 * d + 1) + 2) @(posedge clock);
      @(negedge clock); #1;
      for (int k = 0; k < n; k++) begin
        b = exp_q.pop_front();
        obs = frame_obs(s, d);
        checks++;
        if (obs !== {4'b0111, b, 1'b0}) begin
          fails++;
          $display("FAIL rand_frame %0d at %0d D=%0d: got %b want %b", k, s, d, obs, {4'b0111, b, 1'b0});
        end
        s += 10 * d + 1;
      end
    end
  endtask
  task automatic test_overflow();
    int s0, zeros;
    logic [7:0] b;
    logic [63:0] v;
    bus_write(REG_CTRL, {32'($urandom), 30'($urandom), 2'b00});
    s0 = cyc;
    for (int k = 0; k < DEPTH + 1; k++) begin
      b = 8'($urandom);
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      bus_write(REG_DATA, {32'($urandom), 24'($urandom), b});
    end
    bus_read(REG_DATA, v);
    checks++; if (v !== 64'd0) begin fails++; $display("FAIL full_data_read: got %h want 0", v); end
    bus_read(REG_STATUS, v);
    checks++; if (v !== 64'h80A) begin fails++; $display("FAIL ovf_status: got %h want 80a", v); end
    bus_read(REG_STATUS, v);
    checks++; if (v !== 64'h802) begin fails++; $display("FAIL ovf_clear: got %h want 802", v); end
    @(negedge clock); #1;
    zeros = 0;
    for (int c = s0; c <= cyc; c++) if (tx_log[c] !== 1'b1) zeros++;
    checks++; if (zeros != 0) begin fails++; $display("FAIL tx_idle_disabled: got %0d low cycles want 0", zeros); end
  endtask
  task automatic test_drain_irq();
    int c, s, ones;
    logic [7:0] b;
    logic [12:0] obs;
    bus_write(REG_BAUD, {48'($urandom), 16'd2});
    bus_write(REG_CTRL, {32'($urandom), 30'($urandom), 2'b11});
    c = cyc;
    s = c + 1;
    repeat (8 * 21 + 4) @(posedge clock);
    @(negedge clock); #1;
    ones = 0;
    for (int i = c; i <= s + 8 * 21 - 1; i++) if (irq_log[i] !== 1'b0) ones++;
    checks++; if (ones != 0) begin fails++; $display("FAIL irq_early: got %0d high cycles want 0", ones); end
    checks++; if (irq_log[s + 8 * 21] !== 1'b1) begin fails++; $display("FAIL irq_rise: got %b want 1", irq_log[s + 8 * 21]); end
    for (int k = 0; k < DEPTH; k++) begin
      b = exp_q.pop_front();
      obs = frame_obs(s, 2);
      checks++;
      if (obs !== {4'b0111, b, 1'b0}) begin
        fails++;
        $display("FAIL drain_frame %0d at %0d: got %b want %b", k, s, obs, {4'b0111, b, 1'b0});
      end
      s += 21;
    end
  endtask
  task automatic test_midframe_baud();
    int s;
    logic [7:0] b1, b2;
    logic [12:0] obs;
    bus_write(REG_CTRL, {32'($urandom), 30'($urandom), 2'b01});
    bus_write(REG_BAUD, {48'($urandom), 16'd4});
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    bus_write(REG_DATA, {56'($urandom), b1});
    s = cyc + 1;
    bus_write(REG_DATA, {56'($urandom), b2});
    repeat (8) @(posedge clock);
    bus_write(REG_BAUD, {48'($urandom), 16'd8});
    repeat (41 + 81 + 4) @(posedge clock);
    @(negedge clock); #1;
    obs = frame_obs(s, 4);
    checks++; if (obs !== {4'b0111, b1, 1'b0}) begin fails++; $display("FAIL baud_cur_frame: got %b want %b", obs, {4'b0111, b1, 1'b0}); end
    obs = frame_obs(s + 41, 8);
    checks++; if (obs !== {4'b0111, b2, 1'b0}) begin fails++; $display("FAIL baud_next_frame: got %b want %b", obs, {4'b0111, b2, 1'b0}); end
  endtask
  task automatic test_reset_midframe();
    int s, r, lows;
    logic [63:0] v;
    bus_write(REG_BAUD, {48'($urandom), 16'd4});
    bus_write(REG_DATA, {56'($urandom), 8'h00});
    s = cyc + 1;
    bus_write(REG_DATA, {56'($urandom), 8'($urandom)});
    repeat (10) @(posedge clock);
    @(negedge clock);
    reset = 1;
    @(posedge clock); #1;
    r = cyc;
    checks++; if (tx !== 1'b1) begin fails++; $display("FAIL reset_mid_tx: got %b want 1", tx); end
    checks++; if (tx_log[r - 1] !== 1'b0) begin fails++; $display("FAIL pre_reset_data_bit: got %b want 0 (cycle %0d, frame %0d)", tx_log[r - 1], r - 1, s); end
    @(negedge clock);
    reset = 0;
    exp_q.delete();
    bus_read(REG_STATUS, v);
    checks++; if (v !== 64'h1) begin fails++; $display("FAIL reset_mid_status: got %h want 1", v); end
    bus_read(REG_BAUD, v);
    checks++; if (v !== 64'd868) begin fails++; $display("FAIL reset_mid_baud: got %0d want 868", v); end
    repeat (60) @(posedge clock);
    @(negedge clock); #1;
    lows = 0;
    for (int c = r; c <= cyc; c++) if (tx_log[c] !== 1'b1) lows++;
    checks++; if (lows != 0) begin fails++; $display("FAIL reset_mid_quiet: got %0d low cycles want 0", lows); end
  endtask
  task automatic test_full_push_pop();
    int s;
    logic [7:0] b;
    logic [63:0] v;
    logic [12:0] obs;
    bus_write(REG_BAUD, {48'($urandom), 16'd2});
    for (int k = 0; k < DEPTH; k++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      bus_write(REG_DATA, {56'($urandom), b});
    end
    bus_write(REG_CTRL, {32'($urandom), 30'($urandom), 2'b01});
    s = cyc + 1;
    b = 8'($urandom);
    exp_q.push_back(b);
    bus_write(REG_DATA, {56'($urandom), b});
    bus_read(REG_STATUS, v);
    checks++; if (v !== 64'h806) begin fails++; $display("FAIL push_pop_status: got %h want 806", v); end
    repeat ((DEPTH + 1) * 21 + 4) @(posedge clock);
    @(negedge clock); #1;
    for (int k = 0; k < DEPTH + 1; k++) begin
      b = exp_q.pop_front();
      obs = frame_obs(s, 2);
      checks++;
      if (obs !== {4'b0111, b, 1'b0}) begin
        fails++;
        $display("FAIL push_pop_frame %0d at %0d: got %b want %b", k, s, obs, {4'b0111, b, 1'b0});
      end
      s += 21;
    end
  endtask
  initial begin
    test_reset();
    test_single_frame();
    test_random_frames();
    test_overflow();
    test_drain_irq();
    test_midframe_baud();
    test_reset_midframe();
    test_full_push_pop();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
